// File: rtl/ahb3lite_pkg.sv
// Shared types for the byte serializer: FSM state encoding.
package ahb3lite_pkg;
  typedef enum logic [1:0] {SER_IDLE, SER_RUN, SER_DONE} fifo_ser_state_t;
endpackage

// File: rtl/fifo_byte_serializer_lane_mux.sv
// Picks one byte lane out of a FIFO word, counting from the MSB or the LSB.
module byte_lane_mux #(
  parameter  int WORD_W    = 32,
  parameter  bit MSB_FIRST = 1'b1,
  localparam int BYTES     = WORD_W / 8,
  localparam int LANE_W    = $clog2(BYTES)
) (
  input  logic [WORD_W-1:0] word,
  input  logic [LANE_W-1:0] lane,
  output logic [7:0]        byte_out
);
  always_comb begin
    byte_out = '0;
    for (int i = 0; i < BYTES; i++) begin
      if (lane == LANE_W'(i))
        byte_out = MSB_FIRST ? word[WORD_W-1-8*i -: 8] : word[8*i +: 8];
    end
  end
endmodule

// File: rtl/fifo_byte_serializer.sv
// Drains a show-ahead FIFO one byte at a time for a transfer of `length` bytes.
// Tail bytes of a partial final word are dropped by the last pop.
module fifo_byte_serializer
  import ahb3lite_pkg::*;
#(
  parameter int WORD_W    = 32,
  parameter int LEN_W     = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              CLK,
  input  logic              RESETn,
  input  logic              start,
  input  logic [LEN_W-1:0]  length,
  input  logic              abort,
  input  logic              fifo_empty,
  input  logic [WORD_W-1:0] fifo_dout,
  output logic              fifo_rd_en,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [LEN_W-1:0]  bytes_left,
  output logic              busy,
  output logic              done,
  output logic              aborted
);
  localparam int BYTES  = WORD_W / 8;
  localparam int LANE_W = $clog2(BYTES);

  if (WORD_W % 8 != 0 || WORD_W < 16) begin : g_bad_width
    $error("WORD_W must be a multiple of 8 and at least 16");
  end

  fifo_ser_state_t   state_q, state_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic [LEN_W-1:0]  bytes_left_q, bytes_left_d;
  logic              done_q, done_d;
  logic              aborted_q, aborted_d;

  logic       xfer;
  logic       final_byte;
  logic [7:0] lane_byte;

  byte_lane_mux #(.WORD_W(WORD_W), .MSB_FIRST(MSB_FIRST)) u_mux (
    .word     (fifo_dout),
    .lane     (lane_q),
    .byte_out (lane_byte)
  );

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state_q      <= SER_IDLE;
      lane_q       <= '0;
      bytes_left_q <= '0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      lane_q       <= lane_d;
      bytes_left_q <= bytes_left_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    lane_d       = lane_q;
    bytes_left_d = bytes_left_q;
    aborted_d    = 1'b0;
    case (state_q)
      SER_IDLE: begin
        if (start) begin
          lane_d = '0;
          if (length == '0) begin
            state_d = SER_DONE;
          end else begin
            state_d      = SER_RUN;
            bytes_left_d = length;
          end
        end
      end
      SER_RUN: begin
        // abort wins over a transfer offered in the same cycle
        if (abort) begin
          state_d      = SER_IDLE;
          bytes_left_d = '0;
          lane_d       = '0;
          aborted_d    = 1'b1;
        end else if (xfer) begin
          bytes_left_d = bytes_left_q - LEN_W'(1);
          if (final_byte) begin
            state_d = SER_DONE;
            lane_d  = '0;
          end else if (lane_q == LANE_W'(BYTES-1)) begin
            lane_d = '0;
          end else begin
            lane_d = lane_q + LANE_W'(1);
          end
        end
      end
      SER_DONE: state_d = SER_IDLE;
      default:  state_d = SER_IDLE;
    endcase
    done_d = (state_d == SER_DONE);
  end

  // RESETn gating keeps the combinational outputs quiet while reset is held
  always_comb begin
    out_valid  = RESETn && (state_q == SER_RUN) && !fifo_empty && !abort;
    xfer       = out_valid && out_ready;
    final_byte = (bytes_left_q == LEN_W'(1));
    fifo_rd_en = xfer && ((lane_q == LANE_W'(BYTES-1)) || final_byte);
    out_last   = out_valid && final_byte;
    out_data   = out_valid ? lane_byte : 8'h00;
    busy       = RESETn && (state_q != SER_IDLE);
    bytes_left = bytes_left_q;
    done       = done_q;
    aborted    = aborted_q;
  end
endmodule

// File: tb/tb_fifo_byte_serializer.sv
// Bench for fifo_byte_serializer: byte-stream reference model, directed tables, random traffic.
module tb_fifo_byte_serializer;
  logic CLK = 1'b0;
  logic RESETn = 1'b0;
  always #5 CLK = ~CLK;

  logic        start = 1'b0, abort = 1'b0, fifo_empty = 1'b1, out_ready = 1'b1;
  logic        force_empty = 1'b0;
  logic [15:0] length = '0;
  logic [31:0] fifo_dout = '0;
  logic        fifo_rd_en, out_valid, out_last, busy, done, aborted;
  logic [7:0]  out_data;
  logic [15:0] bytes_left;

  fifo_byte_serializer #(.WORD_W(32), .LEN_W(16), .MSB_FIRST(1'b1)) dut (
    .CLK(CLK), .RESETn(RESETn), .start(start), .length(length), .abort(abort),
    .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .bytes_left(bytes_left), .busy(busy), .done(done), .aborted(aborted)
  );

  // 64-bit LSB-first instance
  logic        b_start = 1'b0, b_empty = 1'b1;
  logic [15:0] b_len = '0;
  logic [63:0] b_dout = '0;
  logic        b_rd, b_valid, b_last, b_busy, b_done, b_aborted;
  logic [7:0]  b_data;
  logic [15:0] b_left;

  fifo_byte_serializer #(.WORD_W(64), .LEN_W(16), .MSB_FIRST(1'b0)) dut_b (
    .CLK(CLK), .RESETn(RESETn), .start(b_start), .length(b_len), .abort(1'b0),
    .fifo_empty(b_empty), .fifo_dout(b_dout), .fifo_rd_en(b_rd),
    .out_data(b_data), .out_valid(b_valid), .out_ready(1'b1), .out_last(b_last),
    .bytes_left(b_left), .busy(b_busy), .done(b_done), .aborted(b_aborted)
  );

  int total = 0, bad = 0;

  // reference model state: remaining bytes and the byte stream still owed
  logic [31:0] fq[$];
  logic [7:0]  exp_q[$];
  int          rem = 0, cur_len = 0;
  logic        done_now = 1'b0, abort_now = 1'b0;
  logic        stall_prev = 1'b0;
  logic [7:0]  stall_data = '0;
  int          pops = 0, nbytes = 0, dones = 0, aborts = 0;
  logic [7:0]  last_b = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] wbyte(input logic [31:0] w, input int k);
    return w[31-8*k -: 8];
  endfunction

  task automatic upd();
    fifo_empty = force_empty || (fq.size() == 0);
    fifo_dout  = (fq.size() != 0) ? fq[0] : 32'h0;
  endtask

  task automatic cyc();
    logic ev, xf, pp, rd_s, dn_nxt, ab_nxt;
    upd();
    @(negedge CLK);
    ev = RESETn && (rem > 0) && !fifo_empty && !abort;
    xf = ev && out_ready;
    pp = xf && ((((cur_len - rem) % 4) == 3) || (rem == 1));
    chk("out_valid", out_valid, ev);
    chk("busy", busy, RESETn && ((rem > 0) || done_now));
    chk("done", done, done_now);
    chk("aborted", aborted, abort_now);
    chk("bytes_left", bytes_left, rem);
    chk("out_last", out_last, ev && (rem == 1));
    chk("fifo_rd_en", fifo_rd_en, pp);
    if (xf) chk("out_data", out_data, (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00);
    if (!out_valid) chk("out_data_idle", out_data, 8'h00);
    if (stall_prev && out_valid) chk("stall_hold", out_data, stall_data);
    stall_prev = out_valid && !out_ready;
    stall_data = out_data;
    rd_s = fifo_rd_en;
    if (fifo_rd_en) pops++;
    if (out_valid && out_ready) begin nbytes++; last_b = out_data; end
    if (done) dones++;
    if (aborted) aborts++;
    dn_nxt = 1'b0; ab_nxt = 1'b0;
    if (!RESETn) begin
      rem = 0; exp_q.delete(); stall_prev = 1'b0;
    end else if (rem > 0 && abort) begin
      ab_nxt = 1'b1; rem = 0; exp_q.delete();
    end else if (xf) begin
      rem--;
      if (rem == 0) dn_nxt = 1'b1;
    end else if (rem == 0 && !done_now && start) begin
      if (length == 0) dn_nxt = 1'b1;
      else begin
        rem = int'(length); cur_len = rem; exp_q.delete();
        foreach (fq[i]) for (int k = 0; k < 4; k++) if (exp_q.size() < rem) exp_q.push_back(wbyte(fq[i], k));
      end
    end
    done_now = dn_nxt; abort_now = ab_nxt;
    @(posedge CLK); #1;
    if (rd_s && fq.size() != 0) void'(fq.pop_front());
  endtask

  task automatic start_xfer(input int len);
    start = 1'b1; length = 16'(len);
    cyc();
    start = 1'b0;
  endtask

  task automatic run_until_idle(input int budget, input bit rnd);
    for (int i = 0; ; i++) begin
      if (i >= budget) begin
        total++; bad++;
        $display("FAIL idle_timeout actual=busy required=idle within %0d cycles", budget);
        break;
      end
      if (rnd) begin
        out_ready   = ($urandom % 4) != 0;
        force_empty = ($urandom % 8) == 0;
        abort       = ($urandom % 50) == 0;
      end
      cyc();
      if (rem == 0 && !done_now && !abort_now) break;
    end
    abort = 1'b0; force_empty = 1'b0; out_ready = 1'b1;
  endtask

  typedef struct {
    int         len;
    logic [31:0] w0, w1;
    int         pops;
    logic [7:0] last;
    int         left;
  } vec_t;
  vec_t vt[6];

  initial begin
    int p0, d0, a0, nb, bn, bp;
    vt[0] = '{8, 32'h11223344, 32'h55667788, 2, 8'h88, 0};
    vt[1] = '{6, 32'h11223344, 32'h55667788, 2, 8'h66, 0};
    vt[2] = '{4, 32'h11223344, 32'h55667788, 1, 8'h44, 1};
    vt[3] = '{1, 32'hA1B2C3D4, 32'h55667788, 1, 8'hA1, 1};
    vt[4] = '{5, 32'h01020304, 32'hF0E0D0C0, 2, 8'hF0, 0};
    vt[5] = '{0, 32'h11223344, 32'h55667788, 0, 8'h00, 2};

    @(posedge CLK); #1;
    cyc(); cyc();
    RESETn = 1'b1;
    cyc();

    foreach (vt[i]) begin
      fq.delete(); fq.push_back(vt[i].w0); fq.push_back(vt[i].w1);
      p0 = pops; d0 = dones;
      start_xfer(vt[i].len);
      run_until_idle(100, 1'b0);
      chk($sformatf("vec%0d_pops", i), pops - p0, vt[i].pops);
      chk($sformatf("vec%0d_done", i), dones - d0, 1);
      if (vt[i].len != 0) chk($sformatf("vec%0d_last", i), last_b, vt[i].last);
      chk($sformatf("vec%0d_left", i), fq.size(), vt[i].left);
    end

    // stall: ready 1,0,0,1 then FIFO starved for 3 cycles mid-word
    fq.delete(); fq.push_back(32'h11223344); fq.push_back(32'h55667788);
    p0 = pops; nb = nbytes;
    start_xfer(8);
    out_ready = 1'b1; cyc();
    out_ready = 1'b0; cyc(); cyc();
    out_ready = 1'b1; cyc();
    force_empty = 1'b1; cyc(); cyc(); cyc();
    force_empty = 1'b0;
    run_until_idle(100, 1'b0);
    chk("stall_bytes", nbytes - nb, 8);
    chk("stall_pops", pops - p0, 2);

    // abort after three bytes, head word must survive
    fq.delete(); fq.push_back(32'h11223344); fq.push_back(32'h55667788);
    p0 = pops; d0 = dones; a0 = aborts;
    start_xfer(8);
    cyc(); cyc(); cyc();
    abort = 1'b1; cyc();
    abort = 1'b0;
    run_until_idle(20, 1'b0);
    chk("abort_pulse", aborts - a0, 1);
    chk("abort_no_done", dones - d0, 0);
    chk("abort_no_pop", pops - p0, 0);
    chk("abort_head", (fq.size() != 0) ? fq[0] : 32'h0, 32'h11223344);
    start_xfer(4);
    run_until_idle(50, 1'b0);
    chk("restart_last", last_b, 8'h44);
    chk("restart_pops", pops - p0, 1);

    // reset mid-transfer
    fq.delete(); fq.push_back(32'h11223344); fq.push_back(32'h55667788);
    p0 = pops; d0 = dones; a0 = aborts;
    start_xfer(8);
    cyc(); cyc();
    RESETn = 1'b0; cyc();
    RESETn = 1'b1; cyc(); cyc();
    chk("rst_busy", busy, 1'b0);
    chk("rst_no_done", dones - d0, 0);
    chk("rst_no_abort", aborts - a0, 0);
    chk("rst_no_pop", pops - p0, 0);
    fq.delete();

    // 64-bit LSB-first word
    bn = 0; bp = 0;
    b_dout = 64'h0807060504030201; b_empty = 1'b0;
    b_start = 1'b1; b_len = 16'd8;
    @(posedge CLK); #1;
    b_start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      logic rd;
      @(negedge CLK);
      if (b_valid) begin chk($sformatf("b_byte%0d", bn), b_data, 8'(bn + 1)); bn++; end
      rd = b_rd;
      if (rd) bp++;
      @(posedge CLK); #1;
      if (rd) b_empty = 1'b1;
    end
    chk("b_count", bn, 8);
    chk("b_pops", bp, 1);

    // random traffic
    for (int t = 0; t < 25; t++) begin
      int nw, len;
      nw = $urandom_range(1, 4);
      fq.delete();
      for (int w = 0; w < nw; w++) fq.push_back($urandom);
      len = $urandom_range(1, nw * 4);
      p0 = pops; nb = nbytes;
      start_xfer(len);
      run_until_idle(400, 1'b1);
    end
    fq.delete();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fifo_byte_serializer.md
FIFO_BYTE_SERIALIZER -- requirements
Module: fifo_byte_serializer

Interface
REQ-001 Parameter WORD_W, default 32: FIFO word width in bits; SHALL be a multiple of 8 and at least 16.
REQ-002 Parameter LEN_W, default 16: width of the transfer byte-length field.
REQ-003 Parameter MSB_FIRST, default 1: 1 emits bits [WORD_W-1:WORD_W-8] first; 0 emits bits [7:0] first.
REQ-004 CLK  input  1  clock; all state updates on rising edge.
REQ-005 RESETn  input  1  reset, synchronous, active-low.
REQ-006 start  input  1  request a transfer of `length` bytes; sampled in IDLE only.
REQ-007 length  input  LEN_W  transfer byte count; latched on accepted start.
REQ-008 abort  input  1  terminate the current transfer.
REQ-009 fifo_empty  input  1  show-ahead FIFO empty flag; fifo_dout is valid when low.
REQ-010 fifo_dout  input  WORD_W  FIFO head word.
REQ-011 fifo_rd_en  output  1  pop the FIFO head word; combinational.
REQ-012 out_data  output  8  serialized byte.
REQ-013 out_valid  output  1  out_data valid.
REQ-014 out_ready  input  1  downstream accepts the byte.
REQ-015 out_last  output  1  current byte is the final byte of the transfer.
REQ-016 bytes_left  output  LEN_W  bytes not yet transferred.
REQ-017 busy  output  1  high in any state other than IDLE.
REQ-018 done  output  1  one-cycle pulse at transfer completion.
REQ-019 aborted  output  1  one-cycle pulse when a transfer is aborted.

Function
REQ-020 The FSM SHALL have states SER_IDLE, SER_RUN and SER_DONE.
REQ-021 IDLE, start=1, length!=0: latch bytes_left=length, lane=0, next state RUN.
REQ-022 IDLE, start=1, length=0: go to DONE with no FIFO pop and no out_valid.
REQ-023 start SHALL be ignored outside IDLE.
REQ-024 BYTES = WORD_W/8; the lane counter width SHALL be $clog2(BYTES).
REQ-025 out_valid SHALL equal (state==RUN && !fifo_empty && !abort).
REQ-026 Byte selection: out_data = byte lane `lane`, counted from the MSB when MSB_FIRST=1, from the LSB otherwise.
REQ-027 A transfer occurs when out_valid && out_ready.
REQ-028 On each transfer: bytes_left decrements by 1; lane increments, wrapping to 0 after BYTES-1.
REQ-029 fifo_rd_en SHALL equal transfer && (lane==BYTES-1 || bytes_left==1).
REQ-030 On a partial final word, the unused tail bytes SHALL be discarded by the final pop.
REQ-031 out_last SHALL equal out_valid && bytes_left==1.
REQ-032 On the transfer with bytes_left==1: next state DONE, lane cleared to 0.
REQ-033 With out_ready low or fifo_empty high, all state SHALL hold; out_data and out_valid SHALL be stable while out_ready is low and the FIFO is not popped.
REQ-034 DONE: done=1 for exactly one cycle, then IDLE.
REQ-035 RUN with abort=1: no transfer, no pop, aborted=1 on the next cycle, next state IDLE, bytes_left cleared; abort SHALL take priority over a simultaneous transfer.
REQ-036 abort in IDLE or DONE SHALL have no effect.
REQ-037 bytes_left SHALL be LEN_W wide and SHALL NOT underflow.
REQ-038 The maximum transfer is 2^LEN_W-1 bytes.

Reset
REQ-039 RESETn=0 at a clock edge: state=IDLE, lane=0, bytes_left=0, done=0, aborted=0.
REQ-040 Combinational outputs under reset: out_valid=0, fifo_rd_en=0, out_last=0, busy=0; out_data=0 whenever out_valid=0.
REQ-041 Reset mid-transfer SHALL discard the transfer with no done pulse, no aborted pulse and no further pops.

Structure
REQ-042 Enum fifo_ser_state_t {SER_IDLE, SER_RUN, SER_DONE} SHALL live in ahb3lite_pkg.
REQ-043 All other constants SHALL be module parameters or derived from them.
REQ-044 The lane multiplexer SHALL be the single sub-module byte_lane_mux #(WORD_W, MSB_FIRST) (word, lane -> byte).
REQ-045 The FSM and counters SHALL remain in the top module.

Verification
REQ-046 WORD_W=32, MSB_FIRST=1, FIFO {0x11223344, 0x55667788}, length=8, out_ready=1 -> bytes 11 22 33 44 55 66 77 88 on consecutive cycles; fifo_rd_en high on bytes 4 and 8; out_last on byte 8; done one cycle later.
REQ-047 length=6, same FIFO -> bytes 11 22 33 44 55 66; second pop on byte 66; 77 and 88 discarded; FIFO empty afterwards.
REQ-048 MSB_FIRST=0, WORD_W=64, word 0x0807060504030201, length=8 -> bytes 01..08; exactly one pop.
REQ-049 out_ready toggles 1,0,0,1 and fifo_empty high for 3 cycles mid-word -> no byte lost or duplicated; out_data held stable during stall; bytes_left correct throughout.
REQ-050 abort after 3 bytes of length=8 -> aborted pulse; no done; no further pops; FIFO head remains 0x11223344; then start length=4 -> bytes 11 22 33 44.
REQ-051 length=0 start -> done after 2 cycles, zero pops; RESETn low mid-transfer -> IDLE, busy=0, no done pulse.
